// File: rtl/inst_queue_pkg.sv
// Shared types for the fetch-to-decode instruction queue: INST/PC types, NOP encoding, entry struct.
// Optional perf counters in inst_queue are enabled with INST_QUEUE_PERF_EN.
package inst_queue_pkg;
  localparam int INST_W = 32;
  localparam int PC_W   = 32;

  typedef logic [INST_W-1:0] inst_t;
  typedef logic [PC_W-1:0]   pc_t;

  // addi x0, x0, 0
  localparam inst_t NOP     = 32'h0000_0013;
  localparam pc_t   PC_STEP = 32'd4;

  typedef struct packed {
    inst_t inst;
    pc_t   pc;
  } iq_entry_t;
endpackage

// File: rtl/inst_queue_chk.sv
// Protocol checker for inst_queue: decode must not accept slot 1 without slot 0.
module inst_queue_chk (
  input logic       clk,
  input logic       rst_n,
  input logic [1:0] deq_accept
);
  // Out-of-order accept is harmless to the queue but indicates a decode bug.
  always @(posedge clk) begin
    if (rst_n) begin
      assert (!(deq_accept[1] && !deq_accept[0]))
        else $error("deq_accept[1] asserted without deq_accept[0]");
    end
  end
endmodule

// File: rtl/inst_queue_ptr_ctrl.sv
// Head/tail/count bookkeeping for inst_queue: enqueue/dequeue counts, enq_ready, deq_valid.
module iq_ptr_ctrl #(
  parameter  int DEPTH = 8,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic [1:0]       enq_valid,
  input  logic [1:0]       deq_accept,
  output logic             enq_ready,
  output logic [1:0]       deq_valid,
  output logic [1:0]       nenq,
  output logic [PTR_W-1:0] head,
  output logic [PTR_W-1:0] tail,
  output logic [PTR_W:0]   count
);
  localparam logic [PTR_W:0] DEPTH_C = (PTR_W+1)'(DEPTH);

  logic [PTR_W-1:0] head_r, tail_r;
  logic [PTR_W:0]   count_r;
  logic [1:0]       ndeq_s;

  assign enq_ready = (DEPTH_C - count_r) >= (PTR_W+1)'(2);
  assign deq_valid = {count_r >= (PTR_W+1)'(2), count_r != (PTR_W+1)'(0)};
  assign head      = head_r;
  assign tail      = tail_r;
  assign count     = count_r;

  // Enqueue count: slot 1 only counts behind slot 0; a lone slot 1 is dropped.
  always_comb begin
    nenq = 2'd0;
    if (enq_ready && enq_valid[0]) begin
      nenq = enq_valid[1] ? 2'd2 : 2'd1;
    end else begin
      nenq = 2'd0;
    end
  end

  // Dequeue count: accepted prefix masked by valid.
  always_comb begin
    ndeq_s = 2'd0;
    if (deq_accept[0] && deq_valid[0]) begin
      ndeq_s = (deq_accept[1] && deq_valid[1]) ? 2'd2 : 2'd1;
    end else begin
      ndeq_s = 2'd0;
    end
  end

  // Pointer and occupancy registers; flush empties the queue in one edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_r  <= '0;
      tail_r  <= '0;
      count_r <= '0;
    end else if (flush) begin
      head_r  <= '0;
      tail_r  <= '0;
      count_r <= '0;
    end else begin
      head_r  <= head_r + PTR_W'(ndeq_s);
      tail_r  <= tail_r + PTR_W'(nenq);
      count_r <= count_r + (PTR_W+1)'(nenq) - (PTR_W+1)'(ndeq_s);
    end
  end
endmodule

// File: rtl/inst_queue.sv
// Fetch-to-decode decoupling FIFO, 2-wide in and out. Define INST_QUEUE_PERF_EN to add
// saturating full/empty cycle counters.
module inst_queue
  import inst_queue_pkg::*;
#(
  parameter  int DEPTH = 8,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   flush,
  input  logic [1:0]             enq_valid,
  input  logic [1:0][INST_W-1:0] enq_inst,
  input  logic [PC_W-1:0]        enq_pc,
  output logic                   enq_ready,
  output logic [1:0]             deq_valid,
  output logic [1:0][INST_W-1:0] deq_inst,
  output logic [1:0][PC_W-1:0]   deq_pc,
  input  logic [1:0]             deq_accept
`ifdef INST_QUEUE_PERF_EN
  ,
  output logic [31:0]            perf_full_cycles,
  output logic [31:0]            perf_empty_cycles
`endif
);
  logic [1:0]       nenq_s;
  logic [PTR_W-1:0] head_s, tail_s, head1_s, tail1_s;
  logic [PTR_W:0]   count_s;
  iq_entry_t        mem_r [DEPTH];

  iq_ptr_ctrl #(.DEPTH(DEPTH)) u_ptr (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush      (flush),
    .enq_valid  (enq_valid),
    .deq_accept (deq_accept),
    .enq_ready  (enq_ready),
    .deq_valid  (deq_valid),
    .nenq       (nenq_s),
    .head       (head_s),
    .tail       (tail_s),
    .count      (count_s)
  );

  assign head1_s = head_s + PTR_W'(1);
  assign tail1_s = tail_s + PTR_W'(1);

  // Entry storage; contents are don't-care outside [head, head+count).
  always_ff @(posedge clk) begin
    if (!flush && nenq_s != 2'd0) begin
      mem_r[tail_s] <= '{inst: enq_inst[0], pc: enq_pc};
    end
    if (!flush && nenq_s == 2'd2) begin
      mem_r[tail1_s] <= '{inst: enq_inst[1], pc: enq_pc + PC_STEP};
    end
  end

  // Oldest-two read mux; invalid slots present NOP at PC 0.
  always_comb begin
    deq_inst = {NOP, NOP};
    deq_pc   = '0;
    if (deq_valid[0]) begin
      deq_inst[0] = mem_r[head_s].inst;
      deq_pc[0]   = mem_r[head_s].pc;
    end else begin
      deq_inst[0] = NOP;
      deq_pc[0]   = '0;
    end
    if (deq_valid[1]) begin
      deq_inst[1] = mem_r[head1_s].inst;
      deq_pc[1]   = mem_r[head1_s].pc;
    end else begin
      deq_inst[1] = NOP;
      deq_pc[1]   = '0;
    end
  end

`ifdef INST_QUEUE_PERF_EN
  // Saturating stall/starve counters; only rst_n clears them, flush does not.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_full_cycles  <= 32'd0;
      perf_empty_cycles <= 32'd0;
    end else begin
      if (enq_valid[0] && !enq_ready && perf_full_cycles != 32'hFFFF_FFFF) begin
        perf_full_cycles <= perf_full_cycles + 32'd1;
      end
      if (count_s == (PTR_W+1)'(0) && !flush && perf_empty_cycles != 32'hFFFF_FFFF) begin
        perf_empty_cycles <= perf_empty_cycles + 32'd1;
      end
    end
  end
`else
  logic unused_count_s;
  assign unused_count_s = ^count_s;
`endif
endmodule

// File: tb/tb_inst_queue.sv
// Self-checking bench for inst_queue: directed scenarios plus random traffic against a queue model.
module tb_inst_queue;
  import inst_queue_pkg::*;

  localparam int DEPTH = 8;

  logic                   clk = 1'b0;
  logic                   rst_n;
  logic                   flush;
  logic [1:0]             enq_valid;
  logic [1:0][INST_W-1:0] enq_inst;
  logic [PC_W-1:0]        enq_pc;
  logic                   enq_ready;
  logic [1:0]             deq_valid;
  logic [1:0][INST_W-1:0] deq_inst;
  logic [1:0][PC_W-1:0]   deq_pc;
  logic [1:0]             deq_accept;
`ifdef INST_QUEUE_PERF_EN
  logic [31:0]            perf_full_cycles, perf_empty_cycles;
`endif

  int vectors = 0;
  int fails   = 0;

  iq_entry_t   q[$];
  int unsigned full_m  = 0;
  int unsigned empty_m = 0;

  inst_queue #(.DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush      (flush),
    .enq_valid  (enq_valid),
    .enq_inst   (enq_inst),
    .enq_pc     (enq_pc),
    .enq_ready  (enq_ready),
    .deq_valid  (deq_valid),
    .deq_inst   (deq_inst),
    .deq_pc     (deq_pc),
    .deq_accept (deq_accept)
`ifdef INST_QUEUE_PERF_EN
    ,
    .perf_full_cycles  (perf_full_cycles),
    .perf_empty_cycles (perf_empty_cycles)
`endif
  );

  inst_queue_chk u_chk (.clk(clk), .rst_n(rst_n), .deq_accept(deq_accept));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp)
      else begin
        fails++;
        $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
  endtask

  task automatic check_all();
    logic [1:0] ev;
    inst_t      i0, i1;
    pc_t        p0, p1;
    ev = {q.size() >= 2, q.size() >= 1};
    i0 = (q.size() >= 1) ? q[0].inst : NOP;
    p0 = (q.size() >= 1) ? q[0].pc   : 32'd0;
    i1 = (q.size() >= 2) ? q[1].inst : NOP;
    p1 = (q.size() >= 2) ? q[1].pc   : 32'd0;
    chk("deq_valid", 64'(deq_valid), 64'(ev));
    chk("deq_inst0", 64'(deq_inst[0]), 64'(i0));
    chk("deq_pc0",   64'(deq_pc[0]),   64'(p0));
    chk("deq_inst1", 64'(deq_inst[1]), 64'(i1));
    chk("deq_pc1",   64'(deq_pc[1]),   64'(p1));
    chk("enq_ready", 64'(enq_ready), 64'((DEPTH - q.size()) >= 2));
`ifdef INST_QUEUE_PERF_EN
    chk("perf_full",  64'(perf_full_cycles),  64'(full_m));
    chk("perf_empty", 64'(perf_empty_cycles), 64'(empty_m));
`endif
  endtask

  // One clock: check outputs, drive inputs, advance the model, step past the edge.
  task automatic cyc(input logic [1:0] ev, input inst_t i0, input inst_t i1, input pc_t pc,
                     input logic [1:0] acc, input logic fl);
    bit ready;
    int nd;
    check_all();
    enq_valid   = ev;
    enq_inst[0] = i0;
    enq_inst[1] = i1;
    enq_pc      = pc;
    deq_accept  = acc;
    flush       = fl;
    ready = (DEPTH - q.size()) >= 2;
    nd = 0;
    if (acc[0] && q.size() >= 1) nd = (acc[1] && q.size() >= 2) ? 2 : 1;
    if (ev[0] && !ready) full_m++;
    if (q.size() == 0 && !fl) empty_m++;
    if (fl) begin
      q.delete();
    end else begin
      repeat (nd) void'(q.pop_front());
      if (ready && ev[0]) begin
        q.push_back('{inst: i0, pc: pc});
        if (ev[1]) q.push_back('{inst: i1, pc: pc + 32'd4});
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle(input logic [1:0] acc);
    cyc(2'b00, NOP, NOP, 32'd0, acc, 1'b0);
  endtask

  initial begin
    pc_t   wpc;
    inst_t ra, rb;
    logic [1:0] ev, acc;
    rst_n = 1'b0; flush = 1'b0; enq_valid = 2'b00; deq_accept = 2'b00;
    enq_inst = {NOP, NOP}; enq_pc = 32'd0;
    repeat (3) @(negedge clk);
    check_all();
    rst_n = 1'b1;

    // Reset then idle
    repeat (10) idle(2'b00);

    // A,B then C with a single-slot enqueue, then accept both
    cyc(2'b11, 32'hAAAA_0001, 32'hBBBB_0002, 32'h100, 2'b00, 1'b0);
    cyc(2'b01, 32'hCCCC_0003, NOP,           32'h108, 2'b00, 1'b0);
    cyc(2'b10, 32'hDEAD_0004, 32'hDEAD_0005, 32'h200, 2'b00, 1'b0);
    idle(2'b11);
    chk("single_left_valid", 64'(deq_valid), 64'(2'b01));
    chk("single_left_pc", 64'(deq_pc[0]), 64'(32'h108));
    idle(2'b01);

    // Fill to full, hold a pair while full, then free two
    for (int i = 0; i < 5; i++)
      cyc(2'b11, $urandom(), $urandom(), 32'h400 + 32'(i * 8), 2'b00, 1'b0);
    chk("full_not_ready", 64'(enq_ready), 64'(1'b0));
    cyc(2'b11, $urandom(), $urandom(), 32'h500, 2'b11, 1'b0);
    chk("ready_after_deq", 64'(enq_ready), 64'(1'b1));
    repeat (4) idle(2'b11);

    // Steady-state 2-in/2-out across pointer wrap
    wpc = 32'd0;
    for (int i = 0; i < 20; i++) begin
      cyc(2'b11, $urandom(), $urandom(), wpc, 2'b11, 1'b0);
      wpc += 32'd8;
    end
    repeat (2) idle(2'b11);

    // Flush at count=5 together with an enqueue and dequeue
    cyc(2'b11, $urandom(), $urandom(), 32'h600, 2'b00, 1'b0);
    cyc(2'b11, $urandom(), $urandom(), 32'h608, 2'b00, 1'b0);
    cyc(2'b01, $urandom(), $urandom(), 32'h610, 2'b00, 1'b0);
    cyc(2'b11, $urandom(), $urandom(), 32'h614, 2'b11, 1'b1);
    chk("flush_empty", 64'(deq_valid), 64'(2'b00));
    cyc(2'b11, 32'h1111_0000, 32'h2222_0000, 32'h700, 2'b00, 1'b0);
    chk("post_flush_head_pc", 64'(deq_pc[0]), 64'(32'h700));

    // Asynchronous reset mid-stream at count=6
    cyc(2'b11, $urandom(), $urandom(), 32'h800, 2'b00, 1'b0);
    cyc(2'b11, $urandom(), $urandom(), 32'h808, 2'b00, 1'b0);
    #2 rst_n = 1'b0;
    q.delete(); full_m = 0; empty_m = 0;
    #1 check_all();
    rst_n = 1'b1;
    #1;

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      ra = $urandom(); rb = $urandom();
      case ($urandom_range(0, 3))
        0: ev = 2'b00;
        1: ev = 2'b01;
        2: ev = 2'b11;
        default: ev = 2'b10;
      endcase
      case ($urandom_range(0, 2))
        0: acc = 2'b00;
        1: acc = 2'b01;
        default: acc = 2'b11;
      endcase
      cyc(ev, ra, rb, $urandom() & 32'hFFFF_FFFC, acc, ($urandom_range(0, 31) == 0));
    end
    check_all();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end
endmodule
